// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers for the sync_fifo_th elastic buffer.
package sync_fifo_pkg;

    // Occupancy needs one extra bit so that a full FIFO (count == depth) is representable.
    function automatic int fifo_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int fifo_ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo_th: one synchronous write port, one asynchronous read port.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_th.sv
// First-word-fall-through synchronous FIFO with programmable almost-full/almost-empty thresholds.
// Define SYNC_FIFO_HWM_EN to build the max_count high-water-mark register.
module sync_fifo_th
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = fifo_cnt_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic [CNT_WIDTH-1:0]  almost_full_th,
    input  logic [CNT_WIDTH-1:0]  almost_empty_th,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_WIDTH-1:0]  max_count
);

    localparam int PW = fifo_ptr_width(FIFO_DEPTH);

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo_th: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 push, pop;

    assign in_ready  = (count_q != CNT_WIDTH'(FIFO_DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_WIDTH'(1);
                2'b01:   count_d = count_q - CNT_WIDTH'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // A push in a clear cycle is discarded, so keep it out of the array as well.
    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .AW         (PW)
    ) u_ram (
        .clk   (clk),
        .we    (push & ~clear),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (out_data)
    );

    assign count        = count_q;
    assign almost_full  = (count_q >= almost_full_th);
    assign almost_empty = (count_q <= almost_empty_th);

`ifdef SYNC_FIFO_HWM_EN
    logic [CNT_WIDTH-1:0] max_count_q, max_count_d;

    // count_d never exceeds FIFO_DEPTH, so the peak saturates there by construction.
    always_comb begin
        max_count_d = max_count_q;
        if (clear) begin
            max_count_d = '0;
        end else if (count_d > max_count_q) begin
            max_count_d = count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_count_q <= '0;
        end else begin
            max_count_q <= max_count_d;
        end
    end

    assign max_count = max_count_q;
`else
    assign max_count = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_th.sv
// Randomized self-checking bench for sync_fifo_th against a queue-based occupancy model.
module tb_sync_fifo_th;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef SYNC_FIFO_HWM_EN
    localparam bit HWM_EN = 1'b1;
`else
    localparam bit HWM_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, clear, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] af_th, ae_th;
    logic          in_ready, out_valid, almost_full, almost_empty;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count, max_count;

    always #5 clk = ~clk;

    sync_fifo_th #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .almost_full_th  (af_th),
        .almost_empty_th (ae_th),
        .count           (count),
        .almost_full     (almost_full),
        .almost_empty    (almost_empty),
        .max_count       (max_count)
    );

    int       n_vec = 0;
    int       n_err = 0;
    logic [DW-1:0] q[$];
    int       hwm = 0;
    bit       did_push, did_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle from the negedge, check outputs against the model, then advance the model.
    task automatic cyc(input bit iv, input bit ordy, input bit clr, input bit r);
        logic [DW-1:0] d;
        logic [DW-1:0] junk;
        d         = DW'($urandom);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
        rst       = r;
        #1;
        chk("count", 32'(count), 32'(q.size()));
        chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= int'(af_th)));
        chk("almost_empty", 32'(almost_empty), 32'(q.size() <= int'(ae_th)));
        chk("max_count", 32'(max_count), HWM_EN ? 32'(hwm) : 32'd0);
        did_push = iv && (q.size() < DEPTH);
        did_pop  = ordy && (q.size() > 0);
        @(posedge clk);
        if (r || clr) begin
            q.delete();
            hwm = 0;
            did_push = 1'b0;
            did_pop  = 1'b0;
        end else begin
            if (did_pop) junk = q.pop_front();
            if (did_push) q.push_back(d);
            if (q.size() > hwm) hwm = q.size();
        end
        @(negedge clk);
    endtask

    task automatic fill_to(input int n);
        for (int i = 0; i < 64 && q.size() < n; i++) cyc(1, 0, 0, 0);
    endtask

    task automatic drain_to(input int n);
        for (int i = 0; i < 64 && q.size() > n; i++) cyc(0, 1, 0, 0);
    endtask

    initial begin
        int got, sent;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        af_th = CW'(14); ae_th = CW'(2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_max_count", 32'(max_count), 32'd0);

        // Fill to full, try one extra push, then drain in order.
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("full_hold_count", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);

        // Simultaneous push and pop at count 1, 8 and 16.
        fill_to(1);
        cyc(1, 1, 0, 0);
        chk("pp1_count", 32'(count), 32'd1);
        fill_to(8);
        cyc(1, 1, 0, 0);
        chk("pp8_count", 32'(count), 32'd8);
        fill_to(16);
        cyc(1, 1, 0, 0);
        chk("pp16_count", 32'(count), 32'd15);
        drain_to(0);

        // Random stream of 40 words with shifting thresholds, including out-of-range ones.
        got = 0; sent = 0;
        for (int c = 0; c < 2000 && got < 40; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                af_th = CW'($urandom_range(0, 31));
                ae_th = CW'($urandom_range(0, 31));
            end
            cyc(sent < 40 && $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 0, 0);
            if (did_push) sent++;
            if (did_pop)  got++;
        end
        chk("stream_popped", 32'(got), 32'd40);
        af_th = CW'(14); ae_th = CW'(2);
        drain_to(0);

        // Clear wins over a concurrent push and pop.
        fill_to(9);
        cyc(1, 1, 1, 0);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        chk("clr_max_count", 32'(max_count), 32'd0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);

        // High-water mark: peak of 11 survives a drain and partial refill.
        fill_to(11);
        drain_to(3);
        fill_to(7);
        #1;
        chk("hwm_peak", 32'(max_count), HWM_EN ? 32'd11 : 32'd0);

        // Mid-stream reset discards everything.
        cyc(1, 1, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        drain_to(0);
        cyc(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
